// File: rtl/bram_port_arbiter_if.sv
// Requester-side bus of the two-port BRAM arbiter: per-requester request
// handshake plus the shared, per-requester-qualified read response.
interface bram_port_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic [1:0]              req_valid;
  logic [1:0]              req_ready;
  logic [1:0]              req_we;
  logic [2*ADDR_WIDTH-1:0] req_addr;
  logic [2*DATA_WIDTH-1:0] req_din;
  logic [1:0]              rsp_valid;
  logic [DATA_WIDTH-1:0]   rsp_dout;

  modport master (
    output req_valid, req_we, req_addr, req_din,
    input  req_ready, rsp_valid, rsp_dout
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_din,
    output req_ready, rsp_valid, rsp_dout
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one BRAM port between two requesters, with
// bounded bursts per grant and a latency-matched read-response pipeline.
module bram_port_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int MAX_BURST    = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic                  axi_clock,
  input  logic                  axil_arst_n,
  bram_port_arbiter_if.slave    req_bus,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_din,
  output logic                  bram_we,
  input  logic [DATA_WIDTH-1:0] bram_dout
);

  localparam int       LAST        = READ_LATENCY - 1;
  localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t                state_r;
  state_t                state_s;
  logic                  rr_r;
  logic                  rr_s;
  logic [3:0]            burst_cnt_r;
  logic [3:0]            burst_cnt_s;
  logic [1:0]            ready_s;
  logic                  hs_s;
  logic                  hs_id_s;
  logic                  gid_s;
  logic                  pick_s;

  logic                  sel_we_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [DATA_WIDTH-1:0] sel_din_s;

  logic                  rd_issue_v_r;
  logic                  rd_issue_id_r;
  logic [LAST:0]         pipe_v_r;
  logic [LAST:0]         pipe_id_r;
  logic [DATA_WIDTH-1:0] rsp_hold_r;

  // Arbitration FSM: next state, round-robin pointer, burst counter, ready.
  always_comb begin
    state_s     = state_r;
    rr_s        = rr_r;
    burst_cnt_s = burst_cnt_r;
    ready_s     = 2'b00;
    hs_s        = 1'b0;
    hs_id_s     = 1'b0;
    gid_s       = 1'b0;
    pick_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (|req_bus.req_valid) begin
          pick_s      = req_bus.req_valid[rr_r] ? rr_r : ~rr_r;
          state_s     = pick_s ? GRANT1 : GRANT0;
          burst_cnt_s = 4'd0;
        end else begin
          state_s = IDLE;
        end
      end
      GRANT0, GRANT1: begin
        gid_s          = (state_r == GRANT1);
        ready_s[gid_s] = 1'b1;
        hs_s           = req_bus.req_valid[gid_s];
        hs_id_s        = gid_s;
        // Leave on release, or when this handshake completes the burst.
        if (!req_bus.req_valid[gid_s] || (burst_cnt_r + 4'd1 == BURST_LIMIT)) begin
          rr_s        = ~gid_s;
          burst_cnt_s = 4'd0;
          if (req_bus.req_valid[~gid_s]) begin
            state_s = gid_s ? GRANT0 : GRANT1;
          end else begin
            state_s = IDLE;
          end
        end else begin
          burst_cnt_s = burst_cnt_r + 4'd1;
        end
      end
      default: begin
        state_s     = IDLE;
        burst_cnt_s = 4'd0;
      end
    endcase
  end

  // FSM state, pointer and burst counter registers.
  always_ff @(posedge axi_clock or negedge axil_arst_n) begin
    if (!axil_arst_n) begin
      state_r     <= IDLE;
      rr_r        <= 1'b0;
      burst_cnt_r <= 4'd0;
    end else begin
      state_r     <= state_s;
      rr_r        <= rr_s;
      burst_cnt_r <= burst_cnt_s;
    end
  end

  // Mux the granted requester's access fields.
  always_comb begin
    sel_we_s   = 1'b0;
    sel_addr_s = {ADDR_WIDTH{1'b0}};
    sel_din_s  = {DATA_WIDTH{1'b0}};
    if (hs_id_s) begin
      sel_we_s   = req_bus.req_we[1];
      sel_addr_s = req_bus.req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH];
      sel_din_s  = req_bus.req_din[2*DATA_WIDTH-1:DATA_WIDTH];
    end else begin
      sel_we_s   = req_bus.req_we[0];
      sel_addr_s = req_bus.req_addr[ADDR_WIDTH-1:0];
      sel_din_s  = req_bus.req_din[DATA_WIDTH-1:0];
    end
  end

  // BRAM port register: address/data hold between accesses, we pulses.
  always_ff @(posedge axi_clock or negedge axil_arst_n) begin
    if (!axil_arst_n) begin
      bram_addr <= {ADDR_WIDTH{1'b0}};
      bram_din  <= {DATA_WIDTH{1'b0}};
      bram_we   <= 1'b0;
    end else if (hs_s) begin
      bram_addr <= sel_addr_s;
      bram_din  <= sel_din_s;
      bram_we   <= sel_we_s;
    end else begin
      bram_we   <= 1'b0;
    end
  end

  // Read tracking: the issue stage aligns with bram_addr, then READ_LATENCY
  // stages follow the BRAM so the last stage lines up with bram_dout.
  always_ff @(posedge axi_clock or negedge axil_arst_n) begin
    if (!axil_arst_n) begin
      rd_issue_v_r  <= 1'b0;
      rd_issue_id_r <= 1'b0;
      pipe_v_r      <= {READ_LATENCY{1'b0}};
      pipe_id_r     <= {READ_LATENCY{1'b0}};
    end else begin
      rd_issue_v_r  <= hs_s & ~sel_we_s;
      rd_issue_id_r <= hs_id_s;
      pipe_v_r[0]   <= rd_issue_v_r;
      pipe_id_r[0]  <= rd_issue_id_r;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_v_r[i]  <= pipe_v_r[i-1];
        pipe_id_r[i] <= pipe_id_r[i-1];
      end
    end
  end

  // Keep the last delivered word so rsp_dout is stable between strobes.
  always_ff @(posedge axi_clock or negedge axil_arst_n) begin
    if (!axil_arst_n) begin
      rsp_hold_r <= {DATA_WIDTH{1'b0}};
    end else if (pipe_v_r[LAST]) begin
      rsp_hold_r <= bram_dout;
    end else begin
      rsp_hold_r <= rsp_hold_r;
    end
  end

  assign req_bus.req_ready = ready_s;
  assign req_bus.rsp_valid = {pipe_v_r[LAST] & pipe_id_r[LAST],
                              pipe_v_r[LAST] & ~pipe_id_r[LAST]};
  assign req_bus.rsp_dout  = pipe_v_r[LAST] ? bram_dout : rsp_hold_r;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench: instance A uses defaults, instance B uses MAX_BURST=1 and
// READ_LATENCY=3; both share stimulus and have their own BRAM model.
module tb_bram_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 10;

  logic axi_clock = 1'b0;
  logic axil_arst_n;
  always #5 axi_clock = ~axi_clock;

  logic [1:0]    t_valid;
  logic [1:0]    t_we;
  logic [AW-1:0] t_addr0, t_addr1;
  logic [DW-1:0] t_din0, t_din1;

  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;

  logic [AW-1:0] bram_addr_a, bram_addr_b;
  logic [DW-1:0] bram_din_a, bram_din_b;
  logic          bram_we_a, bram_we_b;
  logic [DW-1:0] bram_dout_a, bram_dout_b;

  bram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_a ();
  bram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_b ();

  assign bus_a.req_valid = t_valid;
  assign bus_a.req_we    = t_we;
  assign bus_a.req_addr  = {t_addr1, t_addr0};
  assign bus_a.req_din   = {t_din1, t_din0};
  assign bus_b.req_valid = t_valid;
  assign bus_b.req_we    = t_we;
  assign bus_b.req_addr  = {t_addr1, t_addr0};
  assign bus_b.req_din   = {t_din1, t_din0};

  bram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(4), .READ_LATENCY(1)) u_dut_a (
    .axi_clock   (axi_clock),
    .axil_arst_n (axil_arst_n),
    .req_bus     (bus_a.slave),
    .bram_addr   (bram_addr_a),
    .bram_din    (bram_din_a),
    .bram_we     (bram_we_a),
    .bram_dout   (bram_dout_a)
  );

  bram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(1), .READ_LATENCY(3)) u_dut_b (
    .axi_clock   (axi_clock),
    .axil_arst_n (axil_arst_n),
    .req_bus     (bus_b.slave),
    .bram_addr   (bram_addr_b),
    .bram_din    (bram_din_b),
    .bram_we     (bram_we_b),
    .bram_dout   (bram_dout_b)
  );

  logic [DW-1:0] mem_a [0:1023];
  logic [DW-1:0] mem_b [0:1023];
  logic [DW-1:0] b_d1, b_d2, b_d3;

  // BRAM model A: one cycle from registered address to data.
  always @(posedge axi_clock) begin
    if (ld_en) mem_a[ld_addr] <= ld_data;
    else if (bram_we_a) mem_a[bram_addr_a] <= bram_din_a;
    bram_dout_a <= mem_a[bram_addr_a];
  end

  // BRAM model B: three cycles from registered address to data.
  always @(posedge axi_clock) begin
    if (ld_en) mem_b[ld_addr] <= ld_data;
    else if (bram_we_b) mem_b[bram_addr_b] <= bram_din_b;
    b_d1 <= mem_b[bram_addr_b];
    b_d2 <= b_d1;
    b_d3 <= b_d2;
  end
  assign bram_dout_b = b_d3;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_value(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge axi_clock);
    #1;
  endtask

  task automatic do_reset();
    t_valid     = 2'b00;
    t_we        = 2'b00;
    axil_arst_n = 1'b0;
    step();
    step();
    axil_arst_n = 1'b1;
    step();
  endtask

  // Contention accept pattern: IDLE at c=0, then bursts of 4 alternating.
  function automatic logic [1:0] exp_ready_a(input int c);
    if (c < 1) return 2'b00;
    return ((((c - 1) / 4) % 2) == 0) ? 2'b01 : 2'b10;
  endfunction

  // With a burst limit of 1 the grant alternates every cycle.
  function automatic logic [1:0] exp_ready_b(input int c);
    if (c < 1) return 2'b00;
    return (((c - 1) % 2) == 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [DW-1:0] exp_word(input logic [1:0] id);
    return (id == 2'b01) ? 32'hC0DE_0010 : 32'hC0DE_0011;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    axil_arst_n = 1'b0;
    t_valid = 2'b00;  t_we = 2'b00;
    t_addr0 = 10'd0;  t_addr1 = 10'd0;
    t_din0  = 32'd0;  t_din1  = 32'd0;
    ld_en = 1'b0;  ld_addr = 10'd0;  ld_data = 32'd0;
    step();
    ld_en = 1'b1;
    ld_addr = 10'd5;  ld_data = 32'hA5A5_0001; step();
    ld_addr = 10'd16; ld_data = 32'hC0DE_0010; step();
    ld_addr = 10'd17; ld_data = 32'hC0DE_0011; step();
    ld_en = 1'b0;

    check_value("rst req_ready", 64'(bus_a.req_ready), 64'h0);
    check_value("rst rsp_valid", 64'(bus_a.rsp_valid), 64'h0);
    check_value("rst bram_we",   64'(bram_we_a),       64'h0);
    check_value("rst bram_addr", 64'(bram_addr_a),     64'h0);
    check_value("rst bram_din",  64'(bram_din_a),      64'h0);
    check_value("rst rsp_dout",  64'(bus_a.rsp_dout),  64'h0);

    axil_arst_n = 1'b1;
    step();

    // Contention from IDLE with rr = 0, reads of fixed addresses.
    t_addr0 = 10'd16;  t_addr1 = 10'd17;  t_we = 2'b00;  t_valid = 2'b11;
    for (int c = 0; c < 20; c++) begin
      check_value($sformatf("cont ready_a c%0d", c), 64'(bus_a.req_ready), 64'(exp_ready_a(c)));
      check_value($sformatf("cont ready_b c%0d", c), 64'(bus_b.req_ready), 64'(exp_ready_b(c)));
      check_value($sformatf("cont rsp_a c%0d", c), 64'(bus_a.rsp_valid), 64'(exp_ready_a(c - 2)));
      check_value($sformatf("cont rsp_b c%0d", c), 64'(bus_b.rsp_valid), 64'(exp_ready_b(c - 4)));
      if (exp_ready_a(c - 2) != 2'b00)
        check_value($sformatf("cont dout_a c%0d", c), 64'(bus_a.rsp_dout), 64'(exp_word(exp_ready_a(c - 2))));
      if (exp_ready_b(c - 4) != 2'b00)
        check_value($sformatf("cont dout_b c%0d", c), 64'(bus_b.rsp_dout), 64'(exp_word(exp_ready_b(c - 4))));
      step();
    end
    t_valid = 2'b00;
    do_reset();

    // Write 0x1234 to addr 9 via req0, then read it back via req1.
    t_valid = 2'b01;  t_we = 2'b01;  t_addr0 = 10'd9;  t_din0 = 32'h0000_1234;
    check_value("wr idle ready", 64'(bus_a.req_ready), 64'h0);
    step();
    check_value("wr grant ready", 64'(bus_a.req_ready), 64'h1);
    step();
    t_valid = 2'b10;  t_we = 2'b00;  t_addr1 = 10'd9;
    check_value("wr bram_we",   64'(bram_we_a),   64'h1);
    check_value("wr bram_addr", 64'(bram_addr_a), 64'd9);
    check_value("wr bram_din",  64'(bram_din_a),  64'h1234);
    step();
    check_value("raw grant1 ready", 64'(bus_a.req_ready), 64'h2);
    step();
    t_valid = 2'b00;
    check_value("raw bram_addr", 64'(bram_addr_a), 64'd9);
    check_value("raw bram_we",   64'(bram_we_a),   64'h0);
    step();
    check_value("raw rsp_valid", 64'(bus_a.rsp_valid), 64'h2);
    check_value("raw rsp_dout",  64'(bus_a.rsp_dout),  64'h1234);
    step();

    // Early release: req1 drops after 2 accepts while req0 waits.
    t_valid = 2'b10;  t_addr1 = 10'd17;  t_addr0 = 10'd16;
    check_value("rel idle ready", 64'(bus_a.req_ready), 64'h0);
    step();
    t_valid = 2'b11;
    check_value("rel accept1", 64'(bus_a.req_ready), 64'h2);
    step();
    check_value("rel accept2", 64'(bus_a.req_ready), 64'h2);
    step();
    t_valid = 2'b01;
    check_value("rel drop ready", 64'(bus_a.req_ready), 64'h2);
    step();
    check_value("rel grant0", 64'(bus_a.req_ready), 64'h1);
    step();
    t_valid = 2'b00;
    step();
    step();
    step();

    // Reset with one read in flight.
    t_valid = 2'b01;  t_we = 2'b00;  t_addr0 = 10'd16;
    step();
    check_value("mid grant ready", 64'(bus_a.req_ready), 64'h1);
    step();
    t_valid = 2'b00;
    axil_arst_n = 1'b0;
    #1;
    check_value("mid rst ready",     64'(bus_a.req_ready), 64'h0);
    check_value("mid rst rsp_valid", 64'(bus_a.rsp_valid), 64'h0);
    check_value("mid rst bram_addr", 64'(bram_addr_a),     64'h0);
    check_value("mid rst bram_we",   64'(bram_we_a),       64'h0);
    check_value("mid rst rsp_dout",  64'(bus_a.rsp_dout),  64'h0);
    step();
    step();
    axil_arst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_value($sformatf("mid no rsp %0d", i), 64'(bus_a.rsp_valid), 64'h0);
    end

    // Single read of addr 5 served from IDLE after the reset.
    t_valid = 2'b01;  t_we = 2'b00;  t_addr0 = 10'd5;
    check_value("rd idle ready", 64'(bus_a.req_ready), 64'h0);
    step();
    check_value("rd T+1 ready", 64'(bus_a.req_ready), 64'h1);
    step();
    t_valid = 2'b00;
    check_value("rd T+2 bram_addr", 64'(bram_addr_a),     64'd5);
    check_value("rd T+2 rsp_valid", 64'(bus_a.rsp_valid), 64'h0);
    step();
    check_value("rd T+3 rsp_valid", 64'(bus_a.rsp_valid), 64'h1);
    check_value("rd T+3 rsp_dout",  64'(bus_a.rsp_dout),  64'hA5A5_0001);
    step();
    check_value("rd T+4 rsp_valid", 64'(bus_a.rsp_valid), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/bram_port_arbiter.md
BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32: BRAM word width.
REQ-002 Parameter ADDR_WIDTH, default 10: BRAM word-address width.
REQ-003 Parameter MAX_BURST, default 4, range 1-15: maximum consecutive accesses per grant.
REQ-004 Parameter READ_LATENCY, default 1, range 1-3: BRAM cycles from registered address to valid bram_dout.
REQ-005 axi_clock  in  1: single clock; all logic rising-edge.
REQ-006 axil_arst_n  in  1: reset, asynchronous assert, active-low.
REQ-007 req_valid  in  2: per-requester access request, bit k = requester k.
REQ-008 req_ready  out  2: per-requester accept strobe.
REQ-009 req_we  in  2: per-requester write enable (1 = write, 0 = read).
REQ-010 req_addr  in  2*ADDR_WIDTH: per-requester address; requester k uses slice k.
REQ-011 req_din  in  2*DATA_WIDTH: per-requester write data; requester k uses slice k.
REQ-012 rsp_valid  out  2: one-cycle read-data strobe per requester.
REQ-013 rsp_dout  out  DATA_WIDTH: read data, shared; qualified by rsp_valid.
REQ-014 bram_addr  out  ADDR_WIDTH: BRAM fabric-port address.
REQ-015 bram_din  out  DATA_WIDTH: BRAM write data.
REQ-016 bram_we  out  1: BRAM write enable.
REQ-017 bram_dout  in  DATA_WIDTH: BRAM read data.

Function
REQ-018 The FSM SHALL have states IDLE, GRANT0 and GRANT1, plus a 1-bit round-robin pointer rr naming the requester that gets priority.
REQ-019 IDLE: req_ready = 0; if any req_valid, the next state is GRANTk, where k = rr if req_valid[rr], else the other requester.
REQ-020 GRANTk: req_ready[k] = 1 combinationally, other bit 0; a handshake is req_valid[k] & req_ready[k].
REQ-021 The 4-bit burst counter SHALL clear on entering GRANTk and increment on each handshake.
REQ-022 GRANTk SHALL exit when req_valid[k] = 0 or when a handshake brings the count to MAX_BURST.
REQ-023 On exit: go directly to GRANT(1-k) if req_valid[1-k] = 1, else to IDLE; rr SHALL become 1-k.
REQ-024 Within a grant the requester keeps priority even if the other requester is valid, until MAX_BURST is reached.
REQ-025 A handshake at cycle T SHALL drive bram_addr, bram_din and bram_we (registered) at T+1; with no handshake at T, bram_we = 0 at T+1 and addr/din hold.
REQ-026 A read handshake at T SHALL pulse rsp_valid[k] at T+1+READ_LATENCY, with rsp_dout = bram_dout that cycle.
REQ-027 A shift register of depth READ_LATENCY carrying {valid, id} SHALL track in-flight reads; writes insert no entry.
REQ-028 There is no backpressure on responses; requesters SHALL always accept rsp_valid.
REQ-029 Read-after-write to the same address from either requester SHALL return the new data, since accesses are serialised in handshake order.
REQ-030 At most one handshake per cycle; at most one rsp_valid bit high per cycle.

Reset
REQ-031 While axil_arst_n = 0: state = IDLE, rr = 0, counter = 0, req_ready = 0, rsp_valid = 0, bram_we = 0, bram_addr = 0, bram_din = 0, rsp_dout = 0 (registered copy).
REQ-032 Reset asserted mid-burst SHALL drop all in-flight reads: no rsp_valid after release.
REQ-033 After release, arbitration SHALL begin on the first clock edge with axil_arst_n = 1.

Verification
REQ-034 Single read: req_valid = 01, we = 0, addr = 5, BRAM[5] = 0xA5A5_0001 -> req_ready[0] at T+1; bram_addr = 5 at T+2; rsp_valid = 01 with rsp_dout = 0xA5A5_0001 at T+3 (READ_LATENCY = 1).
REQ-035 Contention: both valid continuously from IDLE with rr = 0 -> accept pattern of 4×req0 then 4×req1, alternating, with no idle cycle between grants.
REQ-036 Write then read: req0 writes 0x1234 to addr 9, req1 then reads addr 9 -> rsp_valid = 10, rsp_dout = 0x1234.
REQ-037 Early release: req1 drops valid after 2 accepts while req0 is waiting -> GRANT0 the next cycle, rr = 0.
REQ-038 Reset during a read burst with 1 read in flight -> outputs at reset values; no rsp_valid after release; next request is served from IDLE normally.
REQ-039 MAX_BURST = 1, READ_LATENCY = 3 -> strict alternation under contention; each rsp_valid arrives 4 cycles after its handshake with the correct id.
